// File: rtl/memory_bus_arbiter_if.sv
// 16-bit memory_bus: single-beat request/response handshake between one
// master and one slave. Address, data_in and write_enable stay stable while enable is high.
`timescale 1ns/1ps

interface memory_bus;
    logic        enable;
    logic [15:0] address;
    logic [15:0] data_in;
    logic        write_enable;
    logic [15:0] data_out;
    logic        data_ready;

    modport master (
        output enable,
        output address,
        output data_in,
        output write_enable,
        input  data_out,
        input  data_ready
    );

    modport slave (
        input  enable,
        input  address,
        input  data_in,
        input  write_enable,
        output data_out,
        output data_ready
    );
endinterface

// File: rtl/memory_bus_arbiter.sv
// Two-master round-robin arbiter in front of one memory_bus slave. One transaction at a time.
// An optional slave-response timeout is built in when MEMORY_ARBITER_TIMEOUT_EN is defined.
`timescale 1ns/1ps

module memory_bus_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic       clk,
    input  logic       rst_n,
    memory_bus.slave   m0,
    memory_bus.slave   m1,
    memory_bus.master  s,
    output logic [1:0] grant,
    output logic       timeout_err
);

    localparam logic [1:0]  ST_IDLE      = 2'd0;
    localparam logic [1:0]  ST_BUSY0     = 2'd1;
    localparam logic [1:0]  ST_BUSY1     = 2'd2;
    localparam logic [15:0] TIMEOUT_DATA = 16'hDEAD;

    logic [1:0]  state_reg;
    logic [1:0]  state_next;
    logic        last_grant_reg;
    logic        last_grant_next;

    logic [1:0]  req_enable;
    logic [15:0] req_address [2];
    logic [15:0] req_data_in [2];
    logic [1:0]  req_write_enable;

    logic [1:0]  rsp_ready;
    logic [15:0] rsp_data [2];

    logic        busy;
    logic        sel;
    logic        timeout_hit;

    logic        fwd_enable;
    logic [15:0] fwd_address;
    logic [15:0] fwd_data_in;
    logic        fwd_write_enable;

    // Gather both master ports into indexable arrays so the datapath is written once.
    assign req_enable          = {m1.enable, m0.enable};
    assign req_address[0]      = m0.address;
    assign req_address[1]      = m1.address;
    assign req_data_in[0]      = m0.data_in;
    assign req_data_in[1]      = m1.data_in;
    assign req_write_enable    = {m1.write_enable, m0.write_enable};

    assign m0.data_ready       = rsp_ready[0];
    assign m0.data_out         = rsp_data[0];
    assign m1.data_ready       = rsp_ready[1];
    assign m1.data_out         = rsp_data[1];

    assign busy  = (state_reg == ST_BUSY0) || (state_reg == ST_BUSY1);
    assign sel   = (state_reg == ST_BUSY1);
    assign grant = {state_reg == ST_BUSY1, state_reg == ST_BUSY0};

`ifdef MEMORY_ARBITER_TIMEOUT_EN
    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] tmo_count_reg;
    logic        timeout_err_reg;

    // Count value k-1 in BUSY cycle k, so the limit fires in cycle TIMEOUT_CYCLES.
    assign timeout_hit = busy && !s.data_ready && (tmo_count_reg == TIMEOUT_LAST);
    assign timeout_err = timeout_err_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_count_reg   <= 16'h0000;
            timeout_err_reg <= 1'b0;
        end else begin
            if (busy) begin
                tmo_count_reg <= tmo_count_reg + 16'h0001;
            end else begin
                tmo_count_reg <= 16'h0000;
            end
            if (timeout_hit) begin
                timeout_err_reg <= 1'b1;
            end
        end
    end
`else
    logic unused_timeout_cfg;

    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
    assign timeout_hit        = 1'b0;
    assign timeout_err        = 1'b0;
`endif

    always_comb begin
        state_next      = state_reg;
        last_grant_next = last_grant_reg;
        case (state_reg)
            ST_IDLE: begin
                if (req_enable[0] && req_enable[1]) begin
                    state_next = last_grant_reg ? ST_BUSY0 : ST_BUSY1;
                end else if (req_enable[0]) begin
                    state_next = ST_BUSY0;
                end else if (req_enable[1]) begin
                    state_next = ST_BUSY1;
                end
            end
            ST_BUSY0, ST_BUSY1: begin
                // Completion, abort and timeout all release the bus the same way.
                if (s.data_ready || !req_enable[sel] || timeout_hit) begin
                    state_next      = ST_IDLE;
                    last_grant_next = sel;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= ST_IDLE;
            last_grant_reg <= 1'b1;
        end else begin
            state_reg      <= state_next;
            last_grant_reg <= last_grant_next;
        end
    end

    always_comb begin
        fwd_enable       = 1'b0;
        fwd_address      = 16'h0000;
        fwd_data_in      = 16'h0000;
        fwd_write_enable = 1'b0;
        if (busy) begin
            fwd_enable       = req_enable[sel] && !timeout_hit;
            fwd_address      = req_address[sel];
            fwd_data_in      = req_data_in[sel];
            fwd_write_enable = req_write_enable[sel];
        end
    end

    assign s.enable       = fwd_enable;
    assign s.address      = fwd_address;
    assign s.data_in      = fwd_data_in;
    assign s.write_enable = fwd_write_enable;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_rsp
            logic granted;

            assign granted       = busy && (sel == ((gi == 1) ? 1'b1 : 1'b0));
            assign rsp_ready[gi] = granted && (s.data_ready || timeout_hit);
            assign rsp_data[gi]  = !granted    ? 16'h0000 :
                                   timeout_hit ? TIMEOUT_DATA : s.data_out;
        end
    endgenerate

endmodule

// File: tb/tb_memory_bus_arbiter.sv
// Scoreboard bench for memory_bus_arbiter: two scripted masters, a latency-programmable
// slave model, expected completions queued at issue time and checked on data_ready.
`timescale 1ns/1ps

module tb_memory_bus_arbiter;

`ifdef MEMORY_ARBITER_TIMEOUT_EN
    localparam int TMO = 4;
`else
    localparam int TMO = 256;
`endif

    typedef struct {
        logic [15:0] addr;
        logic [15:0] wdata;
        logic        we;
    } req_t;

    typedef struct {
        int          id;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic        we;
        logic [15:0] rdata;
        logic        chk_slave;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] grant;
    logic       timeout_err;

    memory_bus m0_bus ();
    memory_bus m1_bus ();
    memory_bus s_bus ();

    memory_bus_arbiter #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .m0          (m0_bus),
        .m1          (m1_bus),
        .s           (s_bus),
        .grant       (grant),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    req_t        mq0 [$];
    req_t        mq1 [$];
    exp_t        sb [$];
    bit          active [2];
    int          issue_cyc [2];
    int          done_cyc;
    int          cyc;
    int          tests;
    int          fails;
    int          slave_lat;
    int          scnt;
    bit          slave_fixed;
    logic [15:0] slave_fixed_data;
    logic [15:0] cap_addr;
    logic [15:0] cap_wdata;
    logic        cap_we;
    logic        snap_s_enable;
    logic [1:0]  prev_grant;

    task automatic drive_master(input int n, input bit en, input req_t r);
        if (n == 0) begin
            m0_bus.enable       = en;
            m0_bus.address      = r.addr;
            m0_bus.data_in      = r.wdata;
            m0_bus.write_enable = r.we;
        end else begin
            m1_bus.enable       = en;
            m1_bus.address      = r.addr;
            m1_bus.data_in      = r.wdata;
            m1_bus.write_enable = r.we;
        end
    endtask

    task automatic push_req(input int n, input logic [15:0] a, input logic [15:0] wd,
                            input logic we, input logic [15:0] rd, input logic chk);
        req_t r;
        exp_t e;
        r.addr = a; r.wdata = wd; r.we = we;
        if (n == 0) mq0.push_back(r); else mq1.push_back(r);
        e.id = n; e.addr = a; e.wdata = wd; e.we = we; e.rdata = rd; e.chk_slave = chk;
        sb.push_back(e);
    endtask

    // One clock: slave model, monitor/scoreboard, then master issue for the next cycle.
    task automatic step_cycle();
        exp_t        e;
        req_t        r;
        req_t        zero_r;
        int          id;
        logic [15:0] dout;
        logic        other_rdy;
        logic [15:0] other_dout;
        bit          just_done [2];
        zero_r.addr = 16'h0; zero_r.wdata = 16'h0; zero_r.we = 1'b0;
        just_done[0] = 1'b0;
        just_done[1] = 1'b0;
        @(negedge clk);
        cyc++;
        if (s_bus.enable === 1'b1 && slave_lat > 0) begin
            scnt++;
            if (scnt >= slave_lat) begin
                s_bus.data_ready = 1'b1;
                s_bus.data_out   = slave_fixed ? slave_fixed_data : (s_bus.address ^ 16'h5A5A);
                cap_addr  = s_bus.address;
                cap_wdata = s_bus.data_in;
                cap_we    = s_bus.write_enable;
                scnt = 0;
            end else begin
                s_bus.data_ready = 1'b0;
                s_bus.data_out   = 16'h0000;
            end
        end else begin
            scnt = 0;
            s_bus.data_ready = 1'b0;
            s_bus.data_out   = 16'h0000;
        end
        #1;
        if (grant !== prev_grant && grant !== 2'b00) begin
            tests++;
            if (prev_grant !== 2'b00) begin
                fails++;
                $display("FAIL idle_gap: grant went %b -> %b, required 00 between", prev_grant, grant);
            end
        end
        prev_grant    = grant;
        snap_s_enable = s_bus.enable;
        if (m0_bus.data_ready === 1'b1 || m1_bus.data_ready === 1'b1) begin
            id = (m1_bus.data_ready === 1'b1) ? 1 : 0;
            tests++;
            if (m0_bus.data_ready === 1'b1 && m1_bus.data_ready === 1'b1) begin
                fails++;
                $display("FAIL both_ready: m0 and m1 data_ready both 1, required one");
            end
            dout       = (id == 1) ? m1_bus.data_out : m0_bus.data_out;
            other_rdy  = (id == 1) ? m0_bus.data_ready : m1_bus.data_ready;
            other_dout = (id == 1) ? m0_bus.data_out : m1_bus.data_out;
            $display("[TB] cyc %0d txn m%0d data_out=%h", cyc, id, dout);
            tests++;
            if (sb.size() == 0) begin
                fails++;
                $display("FAIL sb_empty: unexpected data_ready on m%0d data=%h", id, dout);
            end else begin
                e = sb.pop_front();
                tests++;
                if (id != e.id) begin
                    fails++;
                    $display("FAIL order: completion on m%0d, required m%0d", id, e.id);
                end
                tests++;
                if (dout !== e.rdata) begin
                    fails++;
                    $display("FAIL data_out: m%0d got %h, required %h", id, dout, e.rdata);
                end
                if (e.chk_slave) begin
                    tests++;
                    if ({cap_addr, cap_we, cap_wdata} !== {e.addr, e.we, e.wdata}) begin
                        fails++;
                        $display("FAIL slave_req: addr/we/wdata %h/%b/%h, required %h/%b/%h",
                                 cap_addr, cap_we, cap_wdata, e.addr, e.we, e.wdata);
                    end
                end
            end
            tests++;
            if ({other_rdy, other_dout} !== 17'h0) begin
                fails++;
                $display("FAIL other_master: ready/data %b/%h, required 0/0000", other_rdy, other_dout);
            end
            done_cyc = cyc;
            if (active[id]) begin
                active[id] = 1'b0;
                if (id == 0) void'(mq0.pop_front()); else void'(mq1.pop_front());
            end
            drive_master(id, 1'b0, zero_r);
            just_done[id] = 1'b1;
        end
        if (!active[0] && !just_done[0] && mq0.size() > 0) begin
            r = mq0[0];
            drive_master(0, 1'b1, r);
            active[0] = 1'b1;
            issue_cyc[0] = cyc;
        end
        if (!active[1] && !just_done[1] && mq1.size() > 0) begin
            r = mq1[0];
            drive_master(1, 1'b1, r);
            active[1] = 1'b1;
            issue_cyc[1] = cyc;
        end
    endtask

    task automatic run_until_done(input int budget);
        int   n;
        req_t zero_r;
        zero_r.addr = 16'h0; zero_r.wdata = 16'h0; zero_r.we = 1'b0;
        n = 0;
        while ((sb.size() > 0 || active[0] || active[1] || mq0.size() > 0 || mq1.size() > 0)
               && n < budget) begin
            step_cycle();
            n++;
        end
        tests++;
        if (n >= budget) begin
            fails++;
            $display("FAIL budget: %0d transactions still pending after %0d cycles, required 0",
                     sb.size(), budget);
            sb.delete(); mq0.delete(); mq1.delete();
            active[0] = 1'b0; active[1] = 1'b0;
            drive_master(0, 1'b0, zero_r);
            drive_master(1, 1'b0, zero_r);
            step_cycle();
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if (grant !== 2'b00) begin
            fails++;
            $display("FAIL reset_grant: got %b, required 00", grant);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) step_cycle();
        tests++;
        if (grant !== 2'b00) begin
            fails++;
            $display("FAIL idle_grant: got %b, required 00", grant);
        end
        tests++;
        if (s_bus.enable !== 1'b0 || s_bus.address !== 16'h0 || s_bus.write_enable !== 1'b0) begin
            fails++;
            $display("FAIL idle_bus: en/addr/we %b/%h/%b, required 0/0000/0",
                     s_bus.enable, s_bus.address, s_bus.write_enable);
        end
        tests++;
        if (m0_bus.data_ready !== 1'b0 || m1_bus.data_ready !== 1'b0) begin
            fails++;
            $display("FAIL idle_ready: m0/m1 %b/%b, required 0/0", m0_bus.data_ready, m1_bus.data_ready);
        end
        tests++;
        if (timeout_err !== 1'b0) begin
            fails++;
            $display("FAIL reset_timeout_err: got %b, required 0", timeout_err);
        end
    endtask

    task automatic test_tie_rounds();
        slave_fixed = 1'b0;
        slave_lat   = 2;
        for (int r = 0; r < 4; r++) begin
            push_req(0, 16'h0200 + 16'(r), 16'h0000, 1'b0, (16'h0200 + 16'(r)) ^ 16'h5A5A, 1'b1);
            push_req(1, 16'h0300 + 16'(r), 16'hC000 + 16'(r), 1'b1, (16'h0300 + 16'(r)) ^ 16'h5A5A, 1'b1);
            step_cycle();
            tests++;
            if (issue_cyc[0] != issue_cyc[1]) begin
                fails++;
                $display("FAIL tie_issue: m0 at %0d m1 at %0d, required same cycle", issue_cyc[0], issue_cyc[1]);
            end
            run_until_done(40);
        end
    endtask

    task automatic test_single_read();
        slave_fixed      = 1'b1;
        slave_fixed_data = 16'hBEEF;
        slave_lat        = 3;
        push_req(0, 16'h0100, 16'h0000, 1'b0, 16'hBEEF, 1'b1);
        step_cycle();
        #1;
        tests++;
        if (s_bus.enable !== 1'b0 || s_bus.address !== 16'h0000) begin
            fails++;
            $display("FAIL arb_latency0: s en/addr %b/%h, required 0/0000", s_bus.enable, s_bus.address);
        end
        step_cycle();
        tests++;
        if (s_bus.enable !== 1'b1 || grant !== 2'b01 || s_bus.address !== 16'h0100) begin
            fails++;
            $display("FAIL arb_latency1: s en/grant/addr %b/%b/%h, required 1/01/0100",
                     s_bus.enable, grant, s_bus.address);
        end
        run_until_done(20);
        tests++;
        if (done_cyc - issue_cyc[0] != 3) begin
            fails++;
            $display("FAIL read_latency: data_ready %0d cycles after request, required 3",
                     done_cyc - issue_cyc[0]);
        end
        step_cycle();
        tests++;
        if (grant !== 2'b00) begin
            fails++;
            $display("FAIL post_read_idle: grant %b, required 00", grant);
        end
        slave_fixed = 1'b0;
    endtask

    task automatic test_abort();
        req_t zero_r;
        zero_r.addr = 16'h0; zero_r.wdata = 16'h0; zero_r.we = 1'b0;
        slave_lat = 1;
        push_req(0, 16'h0010, 16'h0000, 1'b0, 16'h0010 ^ 16'h5A5A, 1'b1);
        run_until_done(20);
        slave_lat = 0;
        mq1.push_back('{addr: 16'h0040, wdata: 16'h1234, we: 1'b1});
        step_cycle();
        step_cycle();
        tests++;
        if ({grant, s_bus.enable, s_bus.write_enable, s_bus.address, s_bus.data_in} !==
            {2'b10, 1'b1, 1'b1, 16'h0040, 16'h1234}) begin
            fails++;
            $display("FAIL write_fwd: grant/en/we/addr/data %b/%b/%b/%h/%h, required 10/1/1/0040/1234",
                     grant, s_bus.enable, s_bus.write_enable, s_bus.address, s_bus.data_in);
        end
        drive_master(1, 1'b0, zero_r);
        active[1] = 1'b0;
        void'(mq1.pop_front());
        step_cycle();
        tests++;
        if (grant !== 2'b00 || s_bus.enable !== 1'b0) begin
            fails++;
            $display("FAIL abort_idle: grant/en %b/%b, required 00/0", grant, s_bus.enable);
        end
        slave_lat = 2;
        push_req(0, 16'h0050, 16'h0000, 1'b0, 16'h0050 ^ 16'h5A5A, 1'b1);
        push_req(1, 16'h0060, 16'h0000, 1'b0, 16'h0060 ^ 16'h5A5A, 1'b1);
        run_until_done(40);
    endtask

    task automatic test_idle_ready();
        step_cycle();
        s_bus.data_ready = 1'b1;
        s_bus.data_out   = 16'hFFFF;
        #1;
        tests++;
        if ({m0_bus.data_ready, m1_bus.data_ready, m0_bus.data_out, m1_bus.data_out} !== 34'h0) begin
            fails++;
            $display("FAIL idle_slave_ready: m0 %b/%h m1 %b/%h, required 0/0000 on both",
                     m0_bus.data_ready, m0_bus.data_out, m1_bus.data_ready, m1_bus.data_out);
        end
        s_bus.data_ready = 1'b0;
        s_bus.data_out   = 16'h0000;
    endtask

    task automatic test_reset_mid_busy();
        req_t zero_r;
        zero_r.addr = 16'h0; zero_r.wdata = 16'h0; zero_r.we = 1'b0;
        slave_lat = 1;
        push_req(0, 16'h0020, 16'h0000, 1'b0, 16'h0020 ^ 16'h5A5A, 1'b1);
        run_until_done(20);
        slave_lat = 0;
        mq1.push_back('{addr: 16'h0070, wdata: 16'h0000, we: 1'b0});
        step_cycle();
        step_cycle();
        tests++;
        if (grant !== 2'b10) begin
            fails++;
            $display("FAIL busy1_setup: grant %b, required 10", grant);
        end
        #1;
        rst_n = 1'b0;
        #1;
        tests++;
        if ({grant, s_bus.enable, s_bus.address, m1_bus.data_ready, timeout_err} !== 21'h0) begin
            fails++;
            $display("FAIL async_reset: grant/en/addr/m1rdy/terr %b/%b/%h/%b/%b, required 00/0/0000/0/0",
                     grant, s_bus.enable, s_bus.address, m1_bus.data_ready, timeout_err);
        end
        drive_master(1, 1'b0, zero_r);
        active[1] = 1'b0;
        mq1.delete();
        step_cycle();
        step_cycle();
        rst_n = 1'b1;
        slave_lat = 1;
        push_req(0, 16'h0080, 16'h0000, 1'b0, 16'h0080 ^ 16'h5A5A, 1'b1);
        push_req(1, 16'h0090, 16'h0000, 1'b0, 16'h0090 ^ 16'h5A5A, 1'b1);
        run_until_done(40);
    endtask

`ifdef MEMORY_ARBITER_TIMEOUT_EN
    task automatic test_timeout();
        slave_lat = 0;
        tests++;
        if (timeout_err !== 1'b0) begin
            fails++;
            $display("FAIL pre_timeout_err: got %b, required 0", timeout_err);
        end
        push_req(0, 16'h00A0, 16'h0000, 1'b0, 16'hDEAD, 1'b0);
        run_until_done(20);
        tests++;
        if (done_cyc - issue_cyc[0] != 4) begin
            fails++;
            $display("FAIL timeout_cycle: pulse %0d cycles after request, required 4",
                     done_cyc - issue_cyc[0]);
        end
        tests++;
        if (snap_s_enable !== 1'b0) begin
            fails++;
            $display("FAIL timeout_s_enable: got %b, required 0", snap_s_enable);
        end
        step_cycle();
        tests++;
        if (timeout_err !== 1'b1 || grant !== 2'b00) begin
            fails++;
            $display("FAIL timeout_err_set: err/grant %b/%b, required 1/00", timeout_err, grant);
        end
        repeat (5) step_cycle();
        tests++;
        if (timeout_err !== 1'b1) begin
            fails++;
            $display("FAIL timeout_err_sticky: got %b, required 1", timeout_err);
        end
    endtask
`else
    task automatic test_no_timeout();
        req_t zero_r;
        zero_r.addr = 16'h0; zero_r.wdata = 16'h0; zero_r.we = 1'b0;
        slave_lat = 0;
        mq0.push_back('{addr: 16'h00A0, wdata: 16'h0000, we: 1'b0});
        repeat (21) step_cycle();
        tests++;
        if ({grant, m0_bus.data_ready, s_bus.enable, timeout_err} !== {2'b01, 1'b0, 1'b1, 1'b0}) begin
            fails++;
            $display("FAIL wait_forever: grant/rdy/en/terr %b/%b/%b/%b, required 01/0/1/0",
                     grant, m0_bus.data_ready, s_bus.enable, timeout_err);
        end
        drive_master(0, 1'b0, zero_r);
        active[0] = 1'b0;
        mq0.delete();
        step_cycle();
        tests++;
        if (grant !== 2'b00) begin
            fails++;
            $display("FAIL wait_abort: grant %b, required 00", grant);
        end
    endtask
`endif

    initial begin
        req_t zero_r;
        zero_r.addr = 16'h0; zero_r.wdata = 16'h0; zero_r.we = 1'b0;
        tests = 0; fails = 0; cyc = 0; scnt = 0; done_cyc = -1;
        active[0] = 1'b0; active[1] = 1'b0;
        issue_cyc[0] = 0; issue_cyc[1] = 0;
        slave_lat = 0; slave_fixed = 1'b0; slave_fixed_data = 16'h0;
        cap_addr = 16'h0; cap_wdata = 16'h0; cap_we = 1'b0;
        snap_s_enable = 1'b0; prev_grant = 2'b00;
        drive_master(0, 1'b0, zero_r);
        drive_master(1, 1'b0, zero_r);
        s_bus.data_ready = 1'b0;
        s_bus.data_out   = 16'h0000;
        rst_n = 1'b0;

        test_reset();
        test_tie_rounds();
        test_single_read();
        test_abort();
        test_idle_ready();
        test_reset_mid_busy();
`ifdef MEMORY_ARBITER_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL sb_leftover: %0d expected completions never seen, required 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded 200000 ns");
        $fatal(1, "watchdog");
    end

endmodule
